// File: rtl/spi0_pkg.sv
// Shared types and constants for the spi0 master.
// SPI0_MODE3_EN selects SPI mode 3 (CPOL=1, CPHA=1); mode 0 is the default.
package spi0_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        FINISH,
        GAP
    } state_e;

`ifdef SPI0_MODE3_EN
    localparam logic CPOL = 1'b1;
    localparam logic CPHA = 1'b1;
`else
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;
`endif

    localparam int DIV_W = 8;
    localparam int BIT_W = 4;
    localparam int CNT_W = 8;

endpackage

// File: rtl/spi0_sclk_gen.sv
// SCLK half-period generator: toggles every CLK_DIV clocks while enabled and
// flags the upcoming rise/fall for the same clock edge on which SCLK changes.
module spi0_sclk_gen
    import spi0_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic restart_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             tick;

    assign tick   = en_i && (div_q == '0);
    assign rise_o = tick && !sclk_q;
    assign fall_o = tick && sclk_q;
    assign sclk_o = sclk_q;

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!en_i || restart_i) begin
            div_d  = RELOAD;
            sclk_d = CPOL;
        end else if (tick) begin
            div_d  = RELOAD;
            sclk_d = !sclk_q;
        end else begin
            div_d = div_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q  <= RELOAD;
            sclk_q <= CPOL;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi0_master.sv
// Byte-oriented SPI master for the spi0 bus; NSS stays low across a burst until
// the byte flagged last. Define SPI0_MODE3_EN for mode 3, otherwise mode 0.
module spi0_master
    import spi0_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       spi0_clk,
    output logic       spi0_mosi,
    output logic       spi0_nss,
    input  logic       spi0_miso
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d, rx_next;
    logic             mosi_q, mosi_d, nss_q, nss_d, last_q, last_d;
    logic             rx_valid_q, rx_valid_d;
    logic             sclk, rise, fall, sedge, byte_end, load, restart, tx_ready;

    spi0_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (state_q == SHIFT),
        .restart_i(restart),
        .sclk_o   (sclk),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    assign sedge    = rise || fall;
    assign byte_end = (state_q == SHIFT) && sedge && (bit_q == '1);
    // In mode 3 the final sampling edge coincides with byte end, so fold it in here.
    assign rx_next  = rise ? {rx_q[6:0], spi0_miso} : rx_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        mosi_d     = mosi_q;
        nss_d      = nss_q;
        last_d     = last_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_ready   = 1'b0;
        load       = 1'b0;
        restart    = 1'b0;

        if (state_q == SHIFT) begin
            rx_d = rx_next;
            if (fall) begin
                mosi_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
            if (sedge) bit_d = bit_q + BIT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid_i) begin
                    load    = 1'b1;
                    nss_d   = 1'b0;
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    bit_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SHIFT: begin
                if (byte_end) begin
                    rx_data_d  = rx_next;
                    rx_valid_d = 1'b1;
                    bit_d      = '0;
                    if (last_q) begin
                        cnt_d   = HOLD_LD;
                        state_d = FINISH;
                    end else begin
                        tx_ready = 1'b1;
                        if (tx_valid_i) begin
                            load    = 1'b1;
                            restart = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                tx_ready = 1'b1;
                if (tx_valid_i) begin
                    load    = 1'b1;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            FINISH: begin
                if (cnt_q == '0) begin
                    nss_d   = 1'b1;
                    cnt_d   = GAP_LD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Mode 0 presents bit7 immediately; mode 3 waits for the first falling edge.
        if (load) begin
            last_d = tx_last_i;
            if (CPHA) begin
                tx_d = tx_data_i;
            end else begin
                tx_d   = {tx_data_i[6:0], 1'b0};
                mosi_d = tx_data_i[7];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            mosi_q     <= 1'b0;
            nss_q      <= 1'b1;
            last_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            mosi_q     <= mosi_d;
            nss_q      <= nss_d;
            last_q     <= last_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready_o = tx_ready;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q != IDLE);
    assign spi0_clk   = sclk;
    assign spi0_mosi  = mosi_q;
    assign spi0_nss   = nss_q;

endmodule

// File: tb/tb_spi0_master.sv
// Bench for spi0_master: a bus-level slave model records MOSI and serves MISO,
// and timing is checked against cycle formulas built from the block parameters.
module tb_spi0_master;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;
`ifdef SPI0_MODE3_EN
    localparam logic CPOL_E = 1'b1;
`else
    localparam logic CPOL_E = 1'b0;
`endif
    localparam int BYTE_CYC   = 16 * CLK_DIV;
    localparam int FIRST_RISE = CPOL_E ? 2 * CLK_DIV : CLK_DIV;
    localparam int BUDGET     = 2000;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [7:0] tx_data_i = '0;
    logic       tx_last_i = 1'b0;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       busy_o;
    logic       spi0_clk;
    logic       spi0_mosi;
    logic       spi0_nss;
    logic       spi0_miso = 1'b0;

    spi0_master #(
        .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n_i),
        .tx_data_i (tx_data_i),
        .tx_last_i (tx_last_i),
        .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o),
        .rx_data_o (rx_data_o),
        .rx_valid_o(rx_valid_o),
        .busy_o    (busy_o),
        .spi0_clk  (spi0_clk),
        .spi0_mosi (spi0_mosi),
        .spi0_nss  (spi0_nss),
        .spi0_miso (spi0_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus observations (written only by the monitor).
    int         acc_cyc[$], rise_cyc[$], rx_cyc[$], nss_fall_cyc[$], nss_rise_cyc[$], busy_fall_cyc[$];
    logic [7:0] rx_dat[$];
    logic       mosi_bits[$];
    int         fcount = 0, rx_run = 0, rx_run_max = 0;
    logic       prev_sclk = CPOL_E, prev_nss = 1'b1, prev_busy = 1'b0;
    byte_q_t    slave_q;

    function automatic logic slave_bit(input int k);
        if (k < 0 || (k / 8) >= slave_q.size()) return 1'b0;
        return slave_q[k / 8][7 - (k % 8)];
    endfunction

    always @(negedge clk) begin
        if (rst_n_i && tx_valid_i && tx_ready_o) acc_cyc.push_back(cyc + 1);
        if (prev_nss && !spi0_nss) begin
            nss_fall_cyc.push_back(cyc);
            fcount = 0;
            if (!CPOL_E) spi0_miso = slave_bit(0);
        end
        if (!prev_nss && spi0_nss) nss_rise_cyc.push_back(cyc);
        if (!prev_sclk && spi0_clk) begin
            rise_cyc.push_back(cyc);
            mosi_bits.push_back(spi0_mosi);
        end
        if (prev_sclk && !spi0_clk) begin
            fcount++;
            spi0_miso = slave_bit(CPOL_E ? fcount - 1 : fcount);
        end
        if (prev_busy && !busy_o) busy_fall_cyc.push_back(cyc);
        if (rx_valid_o) begin
            rx_cyc.push_back(cyc);
            rx_dat.push_back(rx_data_o);
            rx_run++;
        end else begin
            if (rx_run > rx_run_max) rx_run_max = rx_run;
            rx_run = 0;
        end
        prev_sclk = spi0_clk;
        prev_nss  = spi0_nss;
        prev_busy = busy_o;
    end

    int checks = 0, errors = 0;
    int b_acc, b_rise, b_rx, b_nf, b_nr, b_bf;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qv(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic mark();
        b_acc = acc_cyc.size(); b_rise = rise_cyc.size(); b_rx = rx_dat.size();
        b_nf = nss_fall_cyc.size(); b_nr = nss_rise_cyc.size(); b_bf = busy_fall_cyc.size();
    endtask

    task automatic push(input string tag, input logic [7:0] d, input logic l);
        int n = 0;
        tx_data_i = d; tx_last_i = l; tx_valid_i = 1'b1;
        @(negedge clk);
        while (!tx_ready_o && n < BUDGET) begin @(negedge clk); n++; end
        check({tag, "_accept"}, int'(n < BUDGET), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy_o && n < BUDGET);
        check({tag, "_idle"}, int'(n < BUDGET), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rx(input string tag, input int target);
        int n = 0;
        while (rx_dat.size() < target && n < BUDGET) begin @(negedge clk); n++; end
        check({tag, "_rx_wait"}, int'(n < BUDGET), 1);
    endtask

    task automatic check_bytes(input string tag, input byte_q_t txb, input byte_q_t rxb);
        logic [7:0] m;
        int got;
        check({tag, "_nrx"}, rx_dat.size() - b_rx, rxb.size());
        check({tag, "_nrise"}, rise_cyc.size() - b_rise, 8 * txb.size());
        for (int i = 0; i < txb.size(); i++) begin
            m = '0;
            for (int j = 0; j < 8; j++)
                if (b_rise + 8 * i + j < mosi_bits.size()) m = {m[6:0], mosi_bits[b_rise + 8 * i + j]};
            check($sformatf("%s_mosi%0d", tag, i), int'(m), int'(txb[i]));
            got = (b_rx + i < rx_dat.size()) ? int'(rx_dat[b_rx + i]) : -1;
            check($sformatf("%s_miso%0d", tag, i), got, int'(rxb[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    byte_q_t txb, rxb;
    int      bad, nbytes, a0;

    initial begin
        repeat (3) @(posedge clk); #1;
        check("rst_nss", int'(spi0_nss), 1);
        check("rst_sclk", int'(spi0_clk), int'(CPOL_E));
        check("rst_mosi", int'(spi0_mosi), 0);
        check("rst_rxdata", int'(rx_data_o), 0);
        check("rst_rxvalid", int'(rx_valid_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_ready", int'(tx_ready_o), 1);
        rst_n_i = 1'b1;
        @(posedge clk); #1;

        // Single byte
        mark();
        txb = {8'hA5}; rxb = {8'h3C}; slave_q = rxb;
        push("s1", 8'hA5, 1'b1); tx_valid_i = 1'b0;
        wait_idle("s1");
        check_bytes("s1", txb, rxb);
        a0 = qv(acc_cyc, b_acc);
        check("s1_nss_fall", qv(nss_fall_cyc, b_nf), a0);
        check("s1_first_rise", qv(rise_cyc, b_rise) - a0, CS_SETUP + FIRST_RISE);
        check("s1_rx_latency", qv(rx_cyc, b_rx) - a0, CS_SETUP + BYTE_CYC);
        check("s1_nss_low", qv(nss_rise_cyc, b_nr) - qv(nss_fall_cyc, b_nf), CS_SETUP + BYTE_CYC + CS_HOLD);
        check("s1_gap", qv(busy_fall_cyc, b_bf) - qv(nss_rise_cyc, b_nr), CS_GAP);
        check("s1_idle_sclk", int'(spi0_clk), int'(CPOL_E));

        // Continuous three-byte burst
        mark();
        txb = {8'h01, 8'h02, 8'h03};
        rxb = {8'($urandom), 8'($urandom), 8'($urandom)}; slave_q = rxb;
        push("s2a", 8'h01, 1'b0); push("s2b", 8'h02, 1'b0); push("s2c", 8'h03, 1'b1);
        tx_valid_i = 1'b0;
        wait_idle("s2");
        check_bytes("s2", txb, rxb);
        check("s2_nss_falls", nss_fall_cyc.size() - b_nf, 1);
        check("s2_rx_gap1", qv(rx_cyc, b_rx + 1) - qv(rx_cyc, b_rx), BYTE_CYC);
        check("s2_rx_gap2", qv(rx_cyc, b_rx + 2) - qv(rx_cyc, b_rx + 1), BYTE_CYC);
        bad = 0;
        for (int i = b_rise + 1; i < rise_cyc.size(); i++)
            if (rise_cyc[i] - rise_cyc[i - 1] != 2 * CLK_DIV) bad++;
        check("s2_sclk_contig", bad, 0);

        // Stalled burst
        mark();
        txb = {8'h55, 8'hAA}; rxb = {8'($urandom), 8'($urandom)}; slave_q = rxb;
        push("s3a", 8'h55, 1'b0); tx_valid_i = 1'b0;
        wait_rx("s3", b_rx + 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (spi0_clk !== CPOL_E || spi0_nss !== 1'b0) bad++;
        end
        check("s3_stall_idle", bad, 0);
        push("s3b", 8'hAA, 1'b1); tx_valid_i = 1'b0;
        wait_idle("s3");
        check_bytes("s3", txb, rxb);
        check("s3_nss_falls", nss_fall_cyc.size() - b_nf, 1);
        check("s3_no_setup", qv(rise_cyc, b_rise + 8) - qv(acc_cyc, b_acc + 1), FIRST_RISE);

        // Back-to-back single-byte bursts
        mark();
        txb = {8'($urandom), 8'($urandom)}; rxb = {8'($urandom)}; slave_q = rxb;
        push("s4a", txb[0], 1'b1); push("s4b", txb[1], 1'b1); tx_valid_i = 1'b0;
        wait_idle("s4");
        rxb = {rxb[0], rxb[0]};
        check_bytes("s4", txb, rxb);
        check("s4_ready_low", qv(acc_cyc, b_acc + 1) - qv(rx_cyc, b_rx), CS_HOLD + CS_GAP + 1);
        check("s4_nss_high", qv(nss_fall_cyc, b_nf + 1) - qv(nss_rise_cyc, b_nr), CS_GAP + 1);

        // Reset in the middle of a byte
        mark();
        slave_q = {8'($urandom)};
        push("s5a", 8'hFF, 1'b1); tx_valid_i = 1'b0;
        bad = 0;
        while (rise_cyc.size() - b_rise < 4 && bad < BUDGET) begin @(negedge clk); bad++; end
        check("s5_reach_bit4", int'(bad < BUDGET), 1);
        @(posedge clk); #1;
        rst_n_i = 1'b0;
        #1;
        check("s5_nss", int'(spi0_nss), 1);
        check("s5_sclk", int'(spi0_clk), int'(CPOL_E));
        check("s5_busy", int'(busy_o), 0);
        repeat (3) @(posedge clk); #1;
        rst_n_i = 1'b1;
        @(posedge clk); #1;
        check("s5_no_rx", rx_dat.size() - b_rx, 0);
        mark();
        txb = {8'($urandom)}; rxb = {8'($urandom)}; slave_q = rxb;
        push("s5b", txb[0], 1'b1); tx_valid_i = 1'b0;
        wait_idle("s5");
        check_bytes("s5", txb, rxb);

        // Loopback pattern
        mark();
        txb = {8'hC3}; rxb = {8'h81}; slave_q = rxb;
        push("s6", 8'hC3, 1'b1); tx_valid_i = 1'b0;
        wait_idle("s6");
        check_bytes("s6", txb, rxb);

        // Random bursts with optional stalls
        for (int r = 0; r < 4; r++) begin
            mark();
            nbytes = $urandom_range(1, 3);
            txb = {}; rxb = {};
            for (int i = 0; i < nbytes; i++) begin
                txb.push_back(8'($urandom));
                rxb.push_back(8'($urandom));
            end
            slave_q = rxb;
            for (int i = 0; i < nbytes; i++) begin
                push($sformatf("r%0d_%0d", r, i), txb[i], 1'(i == nbytes - 1));
                if ($urandom_range(0, 1) == 1) begin
                    tx_valid_i = 1'b0;
                    repeat ($urandom_range(1, 40)) @(posedge clk);
                    #1;
                end
            end
            tx_valid_i = 1'b0;
            wait_idle($sformatf("r%0d", r));
            check_bytes($sformatf("r%0d", r), txb, rxb);
            check($sformatf("r%0d_nss_falls", r), nss_fall_cyc.size() - b_nf, 1);
        end

        check("rx_pulse_width", rx_run_max, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
